// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer and the display/status logic
// that decodes its state.
//   state_e : 2-bit timer state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with run/pause/done control. Counts a programmed value
// to zero on enable ticks and emits a one-cycle done pulse at zero; with
// AUTO_RELOAD=1 it reloads and keeps running, acting as a periodic tick source.
//
// Ports:
//   clk        in   1      rising-edge clock
//   i_rst_n    in   1      asynchronous active-low reset
//   i_sclr     in   1      synchronous clear (count/reload <= INIT, IDLE)
//   i_en       in   1      count tick, decrements while running
//   i_load     in   1      load i_load_val (IDLE/DONE only)
//   i_load_val in   WIDTH  value to load
//   i_start    in   1      start, resume or re-arm
//   i_pause    in   1      pause request
//   o_cnt      out  WIDTH  current count (registered)
//   o_busy     out  1      high in RUN or PAUSE
//   o_zero     out  1      o_cnt == 0
//   o_done     out  1      registered one-cycle pulse when the count expires
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] INIT        = 3'b110,
  parameter bit               AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_pause,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_zero,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = 1'b0;

    if (i_sclr) begin
      state_d = S_IDLE;
      cnt_d   = INIT;
      rld_d   = INIT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Pause outranks start even here, so a held pause keeps the timer parked.
          if (i_pause) begin
            state_d = S_IDLE;
          end else if (i_start) begin
            if (cnt_q != ZERO) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else if (i_load) begin
            cnt_d = i_load_val;
            rld_d = i_load_val;
          end
        end

        S_RUN: begin
          if (i_pause) begin
            state_d = S_PAUSE;
          end else if (i_en) begin
            if (cnt_q == ONE) begin
              // A reload value of 1 would expire every tick; suppressing the
              // back-to-back pulse keeps o_done strictly one cycle wide.
              done_d = !done_q;
              if (AUTO_RELOAD) begin
                cnt_d = rld_q;
              end else begin
                cnt_d   = ZERO;
                state_d = S_DONE;
              end
            end else if (cnt_q != ZERO) begin
              cnt_d = cnt_q - ONE;
            end else begin
              state_d = S_DONE;
            end
          end
        end

        S_PAUSE: begin
          if (!i_pause && i_start) begin
            state_d = S_RUN;
          end
        end

        S_DONE: begin
          if (i_pause) begin
            state_d = S_DONE;
          end else if (i_start) begin
            // Re-arming with a zero reload value would leave RUN stuck at 0.
            if (rld_q != ZERO) begin
              cnt_d   = rld_q;
              state_d = S_RUN;
            end
          end else if (i_load) begin
            cnt_d   = i_load_val;
            rld_d   = i_load_val;
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= INIT;
      rld_q   <= INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_busy = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign o_zero = (cnt_q == ZERO);
  assign o_done = done_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int CLK_PERIOD = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclr, en, load, start, pause;
  logic [2:0] load_val;

  logic [2:0] cnt, cnt_ar;
  logic       busy, zero, done;
  logic       busy_ar, zero_ar, done_ar;

  int n_cmp = 0;
  int n_bad = 0;

  always #(CLK_PERIOD/2) clk = ~clk;

  countdown_timer #(.WIDTH(3), .INIT(3'b110), .AUTO_RELOAD(1'b0)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .i_load(load),
    .i_load_val(load_val), .i_start(start), .i_pause(pause),
    .o_cnt(cnt), .o_busy(busy), .o_zero(zero), .o_done(done)
  );

  countdown_timer #(.WIDTH(3), .INIT(3'b110), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .i_load(load),
    .i_load_val(load_val), .i_start(start), .i_pause(pause),
    .o_cnt(cnt_ar), .o_busy(busy_ar), .o_zero(zero_ar), .o_done(done_ar)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sclr = 0; en = 0; load = 0; start = 0; pause = 0; load_val = 3'd0;
  endtask

  initial begin
    logic [2:0] exp_seq [6];
    exp_seq = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    idle_inputs();
    rst_n = 0;

    // Reset then idle
    tick(); tick();
    check("rst_cnt", cnt, 6);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero, 0);
    rst_n = 1;
    en = 1;
    tick();
    check("idle_en_cnt", cnt, 6);
    check("idle_en_busy", busy, 0);

    // Full countdown
    en = 0; start = 1;
    tick();
    check("start_busy", busy, 1);
    check("start_cnt", cnt, 6);
    start = 0; en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("cd_cnt%0d", i), cnt, exp_seq[i]);
      check($sformatf("cd_done%0d", i), done, (i == 5) ? 1 : 0);
    end
    tick();
    check("done_hold_cnt", cnt, 0);
    check("done_single", done, 0);
    check("done_busy", busy, 0);
    check("done_zero", zero, 1);

    // Load in DONE, re-run, re-arm
    en = 0; load = 1; load_val = 3'd2;
    tick();
    check("load_cnt", cnt, 2);
    check("load_busy", busy, 0);
    load = 0; start = 1;
    tick();
    check("load_start_busy", busy, 1);
    start = 0; en = 1;
    tick();
    check("ld_cnt1", cnt, 1);
    check("ld_done1", done, 0);
    tick();
    check("ld_cnt0", cnt, 0);
    check("ld_done0", done, 1);
    en = 0; start = 1;
    tick();
    check("rearm_cnt", cnt, 2);
    check("rearm_busy", busy, 1);
    check("rearm_done", done, 0);

    // Pause / resume
    start = 0; sclr = 1;
    tick();
    check("sclr_cnt", cnt, 6);
    check("sclr_busy", busy, 0);
    sclr = 0; start = 1;
    tick();
    start = 0; en = 1;
    tick(); tick(); tick();
    check("pre_pause_cnt", cnt, 3);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pause_hold%0d", i), cnt, 3);
      check($sformatf("pause_busy%0d", i), busy, 1);
    end
    pause = 0; en = 0; start = 1;
    tick();
    check("resume_cnt", cnt, 3);
    start = 0; en = 1;
    tick();
    check("resume_tick", cnt, 2);
    start = 1; pause = 1;
    tick();
    check("pause_over_start", cnt, 2);
    start = 0; pause = 0;
    tick();
    check("still_paused", cnt, 2);
    check("still_paused_busy", busy, 1);

    // sclr in the done-pulse cycle
    en = 0; start = 1;
    tick();
    start = 0; en = 1;
    tick();
    check("pre_sclr_cnt", cnt, 1);
    tick();
    check("pre_sclr_done", done, 1);
    en = 0; sclr = 1;
    tick();
    check("sclr_drop_done", done, 0);
    check("sclr_drop_cnt", cnt, 6);
    sclr = 0;

    // Async reset mid-RUN at count 4
    start = 1;
    tick();
    start = 0; en = 1;
    tick(); tick();
    check("pre_arst_cnt", cnt, 4);
    check("pre_arst_busy", busy, 1);
    en = 0;
    #3 rst_n = 0;
    #1;
    check("arst_cnt", cnt, 6);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    tick();
    rst_n = 1;

    // Auto-reload with value 2
    load = 1; load_val = 3'd2;
    tick();
    check("ar_load_cnt", cnt_ar, 2);
    load = 0; start = 1;
    tick();
    check("ar_busy", busy_ar, 1);
    start = 0; en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("ar_cnt%0d", i), cnt_ar, (i % 2 == 0) ? 1 : 2);
      check($sformatf("ar_done%0d", i), done_ar, (i % 2 == 0) ? 0 : 1);
      check($sformatf("ar_nz%0d", i), zero_ar, 0);
    end
    check("ar_still_busy", busy_ar, 1);
    en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_countdown_timer
